// File: rtl/vid_fb_scan.sv
// Framebuffer scan-out: programmable sync generator plus 2-stage async SRAM read pipeline.
// Optional macro VID_TESTPAT_EN adds a 'testpat' input that swaps SRAM data for 8 colour bars.
module vid_fb_scan #(
  parameter int H_FRONT    = 48,
  parameter int H_SYNC     = 112,
  parameter int H_BACK     = 248,
  parameter int H_VIS      = 1280,
  parameter int V_FRONT    = 1,
  parameter int V_SYNC     = 3,
  parameter int V_BACK     = 38,
  parameter int V_VIS      = 1024,
  parameter int SRAM_AW    = 18,
  parameter int LINE_SHIFT = 9,
  parameter int COLOR_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SRAM_AW-1:0] base_addr,
  input  logic               zoom_x,
  input  logic               zoom_y,
  input  logic [2:0]         ch_en,
`ifdef VID_TESTPAT_EN
  input  logic               testpat,
`endif
  input  logic [15:0]        sram_dq,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_lb_n,
  output logic               sram_ub_n,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic               frame_start
);

  localparam int H_OFF   = H_FRONT + H_SYNC + H_BACK;
  localparam int H_TOTAL = H_OFF + H_VIS;
  localparam int V_OFF   = V_FRONT + V_SYNC + V_BACK;
  localparam int V_TOTAL = V_OFF + V_VIS;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_FRONT + H_SYNC);
  localparam logic [HW-1:0] HV_BEG = HW'(H_OFF);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_FRONT + V_SYNC);
  localparam logic [VW-1:0] VV_BEG = VW'(V_OFF);

  logic [HW-1:0]      hcnt_q, hcnt_d;
  logic [VW-1:0]      vcnt_q, vcnt_d;
  logic               frame_end;
  logic [SRAM_AW-1:0] base_l_q;
  logic               zoom_x_l_q, zoom_y_l_q;

  // Stage-0 decodes (counter domain)
  logic               hs0, vs0, vis0, fs0, rd0;
  logic [HW-1:0]      x, x_eff;
  logic [VW-1:0]      y, y_eff;
  logic [SRAM_AW-1:0] addr0;

  // Stage-1 and stage-2 registers
  logic [SRAM_AW-1:0] sram_addr_q;
  logic               strobe_n_q;
  logic               hs1_q, vs1_q, vis1_q, fs1_q;
  logic               hs2_q, vs2_q, de2_q, fs2_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic [COLOR_W-1:0] r_src, g_src, b_src;
  logic               dq_unused;

  always_comb begin
    frame_end = 1'b0;
    hcnt_d    = hcnt_q + HW'(1);
    vcnt_d    = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      if (vcnt_q == V_LAST) begin
        vcnt_d    = '0;
        frame_end = 1'b1;
      end else begin
        vcnt_d = vcnt_q + VW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      base_l_q   <= '0;
      zoom_x_l_q <= 1'b0;
      zoom_y_l_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      // Page flip and zoom only take effect on a whole-frame boundary
      if (frame_end) begin
        base_l_q   <= base_addr;
        zoom_x_l_q <= zoom_x;
        zoom_y_l_q <= zoom_y;
      end
    end
  end

  always_comb begin
    hs0   = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vs0   = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    vis0  = (hcnt_q >= HV_BEG) && (vcnt_q >= VV_BEG);
    fs0   = (hcnt_q == '0) && (vcnt_q == '0);
    x     = hcnt_q - HV_BEG;
    y     = vcnt_q - VV_BEG;
    x_eff = zoom_x_l_q ? (x >> 1) : x;
    y_eff = zoom_y_l_q ? (y >> 1) : y;
    addr0 = base_l_q + (SRAM_AW'(y_eff) << LINE_SHIFT) + SRAM_AW'(x_eff);
  end

`ifdef VID_TESTPAT_EN
  localparam int BAR_W = (H_VIS / 8 > 0) ? H_VIS / 8 : 1;
  logic [2:0] bar0, bar1_q;
  logic       tp1_q;

  assign bar0 = 3'(32'(x) / BAR_W);
  assign rd0  = vis0 & ~testpat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar1_q <= '0;
      tp1_q  <= 1'b0;
    end else begin
      bar1_q <= bar0;
      tp1_q  <= testpat;
    end
  end
`else
  assign rd0 = vis0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr_q <= '0;
      strobe_n_q  <= 1'b1;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      vis1_q      <= 1'b0;
      fs1_q       <= 1'b0;
    end else begin
      hs1_q  <= hs0;
      vs1_q  <= vs0;
      vis1_q <= vis0;
      fs1_q  <= fs0;
      if (rd0) begin
        sram_addr_q <= addr0;
        strobe_n_q  <= 1'b0;
      end else begin
        strobe_n_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    r_src = sram_dq[15 -: COLOR_W];
    g_src = sram_dq[10 -: COLOR_W];
    b_src = sram_dq[4 -: COLOR_W];
`ifdef VID_TESTPAT_EN
    if (tp1_q) begin
      r_src = {COLOR_W{bar1_q[2]}};
      g_src = {COLOR_W{bar1_q[1]}};
      b_src = {COLOR_W{bar1_q[0]}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
      de2_q <= 1'b0;
      fs2_q <= 1'b0;
    end else begin
      r_q   <= (vis1_q && ch_en[2]) ? r_src : '0;
      g_q   <= (vis1_q && ch_en[1]) ? g_src : '0;
      b_q   <= (vis1_q && ch_en[0]) ? b_src : '0;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      de2_q <= vis1_q;
      fs2_q <= fs1_q;
    end
  end

  // Low-order RGB565 bits beyond COLOR_W are intentionally dropped
  assign dq_unused   = ^sram_dq;

  assign sram_addr   = sram_addr_q;
  assign sram_ce_n   = strobe_n_q;
  assign sram_oe_n   = strobe_n_q;
  assign sram_lb_n   = strobe_n_q;
  assign sram_ub_n   = strobe_n_q;
  assign sram_we_n   = 1'b1;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign hs          = hs2_q;
  assign vs          = vs2_q;
  assign de          = de2_q;
  assign frame_start = fs2_q;

endmodule

// File: tb/tb_vid_fb_scan.sv
// Scoreboard bench for vid_fb_scan: small timings, hashing SRAM model, random page flips/zoom/ch_en.
module tb_vid_fb_scan;

  localparam int HF = 2, HSY = 3, HB = 3, HV = 8;
  localparam int VF = 1, VSY = 1, VB = 1, VV = 4;
  localparam int AW = 18, LS = 4, CW = 4;
  localparam int HT = HF + HSY + HB + HV;
  localparam int VT = VF + VSY + VB + VV;
  localparam int HOFF = HF + HSY + HB;
  localparam int VOFF = VF + VSY + VB;
  localparam int FRAME = HT * VT;
  localparam int NSTATES = 30 * FRAME;
  localparam int RST_AT = 14 * FRAME + 4 * HT + 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] base_addr;
  logic          zoom_x, zoom_y;
  logic [2:0]    ch_en;
  logic [15:0]   sram_dq;
  logic [AW-1:0] sram_addr;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
  logic [CW-1:0] r, g, b;
  logic          hs, vs, de, frame_start;

  vid_fb_scan #(
    .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB), .H_VIS(HV),
    .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB), .V_VIS(VV),
    .SRAM_AW(AW), .LINE_SHIFT(LS), .COLOR_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .base_addr(base_addr), .zoom_x(zoom_x), .zoom_y(zoom_y),
    .ch_en(ch_en), .sram_dq(sram_dq), .sram_addr(sram_addr),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .de(de), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sram_data(input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'(a);
    return 16'((w * 32'd40503) ^ (w >> 5));
  endfunction

  assign sram_dq = sram_data(sram_addr);

  typedef struct { logic [AW-1:0] addr; logic strb_n; int t; } e1_t;
  typedef struct { logic [3:0] sync; logic [3*CW-1:0] rgb; int t; } e2_t;

  e1_t q1[$];
  e2_t q2[$];
  int  n_chk = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  bit  stim_done = 1'b0;

  // Reference model state: elapsed counter states since reset and per-frame latched settings
  int            t;
  logic [AW-1:0] m_base, last_addr;
  bit            m_zx, m_zy;

  task automatic chk(input string nm, input int st, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s state=%0d: got 0x%0h, want 0x%0h", nm, st, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_sync"}, -1, 32'({hs, vs, de, frame_start}), 32'(4'b1100));
    chk({tag, "_rgb"}, -1, 32'({r, g, b}), 32'(0));
    chk({tag, "_strobes"}, -1, 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'(5'h1f));
    chk({tag, "_addr"}, -1, 32'(sram_addr), 32'(0));
  endtask

  task automatic reset_model();
    t = 0;
    m_base = '0;
    m_zx = 1'b0;
    m_zy = 1'b0;
    last_addr = '0;
  endtask

  task automatic drive_and_push();
    int h, v, mf, x, y, xe, ye;
    bit vis, ehs, evs, efs;
    logic [AW-1:0] addr;
    logic [15:0] d;
    logic [CW-1:0] er, eg, eb;
    e1_t e1;
    e2_t e2;
    h  = t % HT;
    v  = (t / HT) % VT;
    mf = t / FRAME;
    // Inputs for this cycle; ch_en only moves on a blank line
    if (v == 0 && h == 5 && mf >= 1)
      ch_en = (mf == 1) ? 3'b101 : 3'($urandom_range(0, 7));
    if (mf < 4) begin
      if (h == 3 && v == 4) begin
        case (mf)
          0: begin base_addr = 18'h00100; zoom_x = 0; zoom_y = 0; end
          1: begin base_addr = 18'h3FFF0; zoom_x = 0; zoom_y = 0; end
          2: begin base_addr = 18'h00100; zoom_x = 1; zoom_y = 1; end
          default: begin base_addr = AW'($urandom); zoom_x = 1; zoom_y = 0; end
        endcase
      end
    end else if ($urandom_range(0, 15) == 0) begin
      case ($urandom_range(0, 3))
        0: base_addr = 18'h3FFF0;
        1: base_addr = 18'h00100;
        default: base_addr = AW'($urandom);
      endcase
      zoom_x = 1'($urandom_range(0, 1));
      zoom_y = 1'($urandom_range(0, 1));
    end
    // Expected behaviour for this counter state
    ehs = !(h >= HF && h < HF + HSY);
    evs = !(v >= VF && v < VF + VSY);
    vis = (h >= HOFF) && (v >= VOFF);
    efs = (h == 0) && (v == 0);
    x  = h - HOFF;
    y  = v - VOFF;
    xe = m_zx ? x / 2 : x;
    ye = m_zy ? y / 2 : y;
    addr = vis ? AW'((int'(m_base) + ye * (1 << LS) + xe) % (1 << AW)) : last_addr;
    last_addr = addr;
    d  = sram_data(addr);
    er = (vis && ch_en[2]) ? CW'(d >> (16 - CW)) : '0;
    eg = (vis && ch_en[1]) ? CW'(d >> (11 - CW)) : '0;
    eb = (vis && ch_en[0]) ? CW'(d >> (5 - CW)) : '0;
    e1.addr = addr;
    e1.strb_n = !vis;
    e1.t = t;
    e2.sync = {ehs, evs, vis, efs};
    e2.rgb = {er, eg, eb};
    e2.t = t;
    q1.push_back(e1);
    q2.push_back(e2);
    if (h == HT - 1 && v == VT - 1) begin
      m_base = base_addr;
      m_zx = zoom_x;
      m_zy = zoom_y;
    end
    t++;
  endtask

  // Monitor: stage-1 outputs reflect the state pushed last, stage-2 the one before it
  initial begin
    e1_t e1;
    e2_t e2;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (q1.size() > 0) begin
          e1 = q1.pop_front();
          chk("sram_addr", e1.t, 32'(sram_addr), 32'(e1.addr));
          chk("strobes", e1.t, 32'({sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n, sram_we_n}),
              32'({{4{e1.strb_n}}, 1'b1}));
        end
        if (q2.size() >= 2 || (stim_done && q2.size() > 0)) begin
          e2 = q2.pop_front();
          chk("hs_vs_de_fs", e2.t, 32'({hs, vs, de, frame_start}), 32'(e2.sync));
          chk("rgb", e2.t, 32'({r, g, b}), 32'(e2.rgb));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    base_addr = 18'h00100;
    zoom_x = 1'b0;
    zoom_y = 1'b0;
    ch_en = 3'b111;
    repeat (3) @(negedge clk);
    check_reset("reset_init");
    reset_model();
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < NSTATES; i++) begin
      if (i == RST_AT) begin
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset("reset_midline");
        @(negedge clk);
        @(negedge clk);
        q1.delete();
        q2.delete();
        reset_model();
        rst_n = 1'b1;
        mon_en = 1'b1;
      end
      drive_and_push();
      if (i == NSTATES - 1) stim_done = 1'b1;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("queues_drained", -1, 32'(q1.size() + q2.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
